// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Register-hazard scoreboard sitting between decode and issue. Every
// in-flight register write is tagged; each decode-stage source is classified
// as clean (register file), forwardable (bypass network) or hazardous (stall).
// Entries retire on a tagged writeback so that stale writebacks from
// overwritten (WAW) producers are ignored.
//
// Ports:
//   clk, reset (async, active-low), clear (sync flush, keeps the tag counter)
//   issue_valid/issue_regwrite/issue_dst/issue_lat/issue_src/issue_src_used
//       - decode-stage instruction presented for issue
//   stall, fwd_hit, issue_tag - combinational from registered state + issue_*
//   wb_valid/wb_dst/wb_tag    - tagged writeback from the writeback stage
//   busy_vec, pending_cnt     - registered views of the scoreboard state
module reg_scoreboard #(
    parameter int NREG    = 32,
    parameter int NSRC    = 2,
    parameter int MAX_LAT = 7,
    parameter int TAG_W   = 4,
    localparam int AW     = $clog2(NREG),
    localparam int CW     = $clog2(MAX_LAT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                issue_valid,
    input  logic                issue_regwrite,
    input  logic [AW-1:0]       issue_dst,
    input  logic [CW-1:0]       issue_lat,
    input  logic [NSRC*AW-1:0]  issue_src,
    input  logic [NSRC-1:0]     issue_src_used,
    output logic                stall,
    output logic [NSRC-1:0]     fwd_hit,
    output logic [TAG_W-1:0]    issue_tag,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_dst,
    input  logic [TAG_W-1:0]    wb_tag,
    output logic [NREG-1:0]     busy_vec,
    output logic [AW:0]         pending_cnt
);

    // Number of set bits in a register-wide vector.
    function automatic logic [AW:0] popcount(input logic [NREG-1:0] vec);
        logic [AW:0] sum;
        sum = (AW+1)'(0);
        for (int i = 0; i < NREG; i++) begin
            sum = sum + (AW+1)'(vec[i]);
        end
        return sum;
    endfunction

    // Registered scoreboard state
    logic [NREG-1:0]   busy_r;
    logic [CW-1:0]     cnt_r [NREG];
    logic [TAG_W-1:0]  tag_r [NREG];
    logic [TAG_W-1:0]  next_tag_r;
    logic [AW:0]       pending_r;

    // Next-state values
    logic [NREG-1:0]   busy_nxt_s;
    logic [CW-1:0]     cnt_nxt_s [NREG];
    logic [TAG_W-1:0]  tag_nxt_s [NREG];
    logic [TAG_W-1:0]  next_tag_nxt_s;

    // Per-source decode
    logic [AW-1:0]     src_addr_s  [NSRC];
    logic [NSRC-1:0]   src_track_s;
    logic [NSRC-1:0]   src_haz_s;

    logic              accept_s;
    logic              load_s;
    logic              wb_retire_s;
    logic [CW-1:0]     lat_sat_s;

    // A source only matters when it is used, non-zero and has a pending
    // write; the remaining countdown then picks stall versus bypass.
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        assign src_addr_s[gi]  = issue_src[gi*AW +: AW];
        assign src_track_s[gi] = issue_src_used[gi]
                               & (src_addr_s[gi] != AW'(0))
                               & busy_r[src_addr_s[gi]];
        assign src_haz_s[gi]   = src_track_s[gi]
                               & (cnt_r[src_addr_s[gi]] != CW'(0));
        assign fwd_hit[gi]     = issue_valid & src_track_s[gi]
                               & (cnt_r[src_addr_s[gi]] == CW'(0));
    end

    assign stall     = issue_valid & (|src_haz_s);
    assign issue_tag = next_tag_r;
    assign accept_s  = issue_valid & ~stall;
    assign load_s    = accept_s & issue_regwrite & (issue_dst != AW'(0));

    // Widened compare keeps the saturation generic for any CW/MAX_LAT pair.
    assign lat_sat_s = ({1'b0, issue_lat} > (CW+1)'(MAX_LAT)) ? CW'(MAX_LAT)
                                                              : issue_lat;

    // Writeback retires only the producer that currently owns the entry.
    assign wb_retire_s = wb_valid & (wb_dst != AW'(0)) & busy_r[wb_dst]
                       & (tag_r[wb_dst] == wb_tag);

    // Next-state: clear beats issue, issue beats writeback, idle entries count down.
    always_comb begin
        busy_nxt_s     = busy_r;
        next_tag_nxt_s = next_tag_r;
        for (int r = 0; r < NREG; r++) begin
            tag_nxt_s[r] = tag_r[r];
            cnt_nxt_s[r] = (busy_r[r] && (cnt_r[r] != CW'(0))) ? (cnt_r[r] - CW'(1))
                                                               : cnt_r[r];
        end

        if (clear) begin
            busy_nxt_s = {NREG{1'b0}};
            for (int r = 0; r < NREG; r++) begin
                cnt_nxt_s[r] = CW'(0);
            end
        end else begin
            busy_nxt_s[wb_dst] = busy_r[wb_dst] & ~wb_retire_s;
            if (load_s) begin
                busy_nxt_s[issue_dst] = 1'b1;
                cnt_nxt_s[issue_dst]  = lat_sat_s;
                tag_nxt_s[issue_dst]  = next_tag_r;
                next_tag_nxt_s        = next_tag_r + TAG_W'(1);
            end else begin
                next_tag_nxt_s        = next_tag_r;
            end
        end
    end

    // State registers; pending count is registered from the next busy vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r     <= {NREG{1'b0}};
            next_tag_r <= TAG_W'(0);
            pending_r  <= (AW+1)'(0);
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= CW'(0);
                tag_r[r] <= TAG_W'(0);
            end
        end else begin
            busy_r     <= busy_nxt_s;
            next_tag_r <= next_tag_nxt_s;
            pending_r  <= popcount(busy_nxt_s);
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= cnt_nxt_s[r];
                tag_r[r] <= tag_nxt_s[r];
            end
        end
    end

    assign busy_vec    = busy_r;
    assign pending_cnt = pending_r;

endmodule
